// File: rtl/unidade_controle.sv
`default_nettype none
// ============================================================================
// Module  : unidade_controle
// Purpose : Multicycle control FSM for the RV32I-subset datapath (fetch,
//           decode, execute, memory, write-back) with memory handshake.
// Revision: 1.0 - initial release
// ============================================================================
module unidade_controle #(
   parameter int LARGURA_CONT = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    executar,
   input  logic [6:0]              opcode,
   input  logic [2:0]              funct3,
   input  logic                    zero,
   input  logic                    mem_pronto,
   output logic [3:0]              estado,
   output logic                    mem_req,
   output logic                    mem_le,
   output logic                    mem_escreve,
   output logic                    ir_escreve,
   output logic                    reg_escreve,
   output logic                    mem_para_reg,
   output logic                    pc_escreve,
   output logic                    pc_fonte,
   output logic [1:0]              ula_op,
   output logic                    ula_fonte_b,
   output logic                    parada,
   output logic [LARGURA_CONT-1:0] contador
);

   typedef enum logic [3:0] {
      BUSCA      = 4'b0000,
      DECODIFICA = 4'b0001,
      EXECUTA    = 4'b0010,
      MEMORIA    = 4'b0011,
      ESCRITA    = 4'b0100,
      ERRO       = 4'b1111
   } estado_t;

   typedef enum logic [2:0] {
      CL_NENHUMA = 3'd0,
      CL_LOAD    = 3'd1,
      CL_ALUI    = 3'd2,
      CL_STORE   = 3'd3,
      CL_RTYPE   = 3'd4,
      CL_BRANCH  = 3'd5
   } classe_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_ALUI   = 7'b0010011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   estado_t                 estado_q, estado_d;
   classe_t                 classe_q, classe_d;
   logic [LARGURA_CONT-1:0] contador_q, contador_d;

   logic       w_mem_req, w_mem_le, w_mem_escreve, w_ir_escreve, w_reg_escreve;
   logic       w_mem_para_reg, w_pc_escreve, w_pc_fonte, w_ula_fonte_b;
   logic [1:0] w_ula_op;
   logic       w_retira;
   logic       w_desvio_tomado;

   // beq taken on equal, bne taken on not-equal; other funct3 never branch
   assign w_desvio_tomado = ((funct3 == 3'b000) &&  zero) ||
                            ((funct3 == 3'b001) && !zero);

   always_comb begin
      estado_d       = estado_q;
      classe_d       = classe_q;
      contador_d     = contador_q;
      w_mem_req      = 1'b0;
      w_mem_le       = 1'b0;
      w_mem_escreve  = 1'b0;
      w_ir_escreve   = 1'b0;
      w_reg_escreve  = 1'b0;
      w_mem_para_reg = 1'b0;
      w_pc_escreve   = 1'b0;
      w_pc_fonte     = 1'b0;
      w_ula_op       = 2'b00;
      w_ula_fonte_b  = 1'b0;
      w_retira       = 1'b0;

      case (estado_q)
         BUSCA: begin
            if (executar) begin
               w_mem_req = 1'b1;
               w_mem_le  = 1'b1;
               if (mem_pronto) begin
                  w_ir_escreve = 1'b1;
                  estado_d     = DECODIFICA;
               end
            end
         end

         DECODIFICA: begin
            estado_d = EXECUTA;
            case (opcode)
               OP_LOAD:   classe_d = CL_LOAD;
               OP_ALUI:   classe_d = CL_ALUI;
               OP_STORE:  classe_d = CL_STORE;
               OP_RTYPE:  classe_d = CL_RTYPE;
               OP_BRANCH: classe_d = CL_BRANCH;
               default: begin
                  classe_d = CL_NENHUMA;
                  estado_d = ERRO;
               end
            endcase
         end

         EXECUTA: begin
            case (classe_q)
               CL_LOAD, CL_STORE: begin
                  w_ula_fonte_b = 1'b1;
                  estado_d      = MEMORIA;
               end
               CL_ALUI: begin
                  w_ula_op      = 2'b10;
                  w_ula_fonte_b = 1'b1;
                  estado_d      = ESCRITA;
               end
               CL_RTYPE: begin
                  w_ula_op = 2'b10;
                  estado_d = ESCRITA;
               end
               CL_BRANCH: begin
                  w_ula_op     = 2'b01;
                  w_pc_escreve = 1'b1;
                  w_pc_fonte   = w_desvio_tomado;
                  w_retira     = 1'b1;
                  estado_d     = BUSCA;
               end
               default: estado_d = ERRO;
            endcase
         end

         MEMORIA: begin
            w_mem_req     = 1'b1;
            w_mem_le      = (classe_q == CL_LOAD);
            w_mem_escreve = (classe_q == CL_STORE);
            if (mem_pronto) begin
               if (classe_q == CL_LOAD) begin
                  estado_d = ESCRITA;
               end else begin
                  w_pc_escreve = 1'b1;
                  w_retira     = 1'b1;
                  estado_d     = BUSCA;
               end
            end
         end

         ESCRITA: begin
            w_reg_escreve  = 1'b1;
            w_mem_para_reg = (classe_q == CL_LOAD);
            w_pc_escreve   = 1'b1;
            w_retira       = 1'b1;
            estado_d       = BUSCA;
         end

         ERRO: estado_d = ERRO;

         default: estado_d = ERRO;
      endcase

      if (w_retira) begin
         contador_d = contador_q + LARGURA_CONT'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado_q   <= BUSCA;
         classe_q   <= CL_NENHUMA;
         contador_q <= '0;
      end else begin
         estado_q   <= estado_d;
         classe_q   <= classe_d;
         contador_q <= contador_d;
      end
   end

   // Gating with rst_n drops every request the instant reset asserts
   assign mem_req      = rst_n & w_mem_req;
   assign mem_le       = rst_n & w_mem_le;
   assign mem_escreve  = rst_n & w_mem_escreve;
   assign ir_escreve   = rst_n & w_ir_escreve;
   assign reg_escreve  = rst_n & w_reg_escreve;
   assign mem_para_reg = rst_n & w_mem_para_reg;
   assign pc_escreve   = rst_n & w_pc_escreve;
   assign pc_fonte     = rst_n & w_pc_fonte;
   assign ula_op       = rst_n ? w_ula_op : 2'b00;
   assign ula_fonte_b  = rst_n & w_ula_fonte_b;
   assign estado       = estado_q;
   assign parada       = (estado_q == ERRO);
   assign contador     = contador_q;

endmodule
`default_nettype wire
